alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; all widths below scale with WIDTH.
REQ-002 clk  input  1  rising-edge clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low (sampled on clk rising edge only).
REQ-004 A  input  WIDTH  operand A, unsigned/two's-complement agnostic.
REQ-005 B  input  WIDTH  operand B.
REQ-006 control  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-007 in_valid  input  1  operands/opcode valid this cycle.
REQ-008 C_out  output  1  carry flag (registered).
REQ-009 Zero  output  1  zero flag (registered).
REQ-010 Negative  output  1  sign flag (registered).
REQ-011 result  output  WIDTH  operation result (registered).
REQ-012 out_valid  output  1  result/flags updated by the previous cycle's valid operation.

Function
REQ-013 ADD: result = (A + B) mod 2^WIDTH; C_out = carry out of bit WIDTH-1.
REQ-014 SUB: result = (A - B) mod 2^WIDTH, computed as A + ~B + 1; C_out = carry out of that sum (1 = no borrow, i.e. A >= B unsigned).
REQ-015 AND: result = A & B bitwise; C_out = 0.
REQ-016 OR: result = A | B bitwise; C_out = 0.
REQ-017 Zero = 1 exactly when result is all zeros, for every opcode.
REQ-018 Negative = result[WIDTH-1], for every opcode.
REQ-019 Latency exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on result/flags after edge N, with out_valid=1 for that one cycle.
REQ-020 in_valid=0 at an edge: result and flags hold previous values; out_valid=0.
REQ-021 Back-to-back in_valid=1 cycles: one result per cycle, no bubbles, no stalls.
REQ-022 Wrap-around: ADD overflow wraps silently (e.g. 255+1 -> 0, C_out=1, Zero=1); SUB underflow wraps (e.g. 0-1 -> 255, C_out=0, Negative=1).
REQ-023 Inputs fully combinationally decoded into the output registers; no internal state besides output registers.

Reset
REQ-024 rst_n=0 at a rising edge: result=0, C_out=0, Zero=1, Negative=0, out_valid=0 (and V=0 when present), regardless of in_valid.
REQ-025 Reset takes priority over a simultaneous in_valid=1; that operation is discarded, not delayed.
REQ-026 First valid operation after rst_n returns high is processed normally on the next edge.

Configuration
REQ-027 Macro ALU_OVERFLOW_EN defined: extra output V (1 bit, registered, after Negative in port order) = signed two's-complement overflow for ADD/SUB (operands same sign for ADD / different sign for SUB, result sign differs from A), V=0 for AND/OR.
REQ-028 Macro ALU_OVERFLOW_EN undefined: no V port, no overflow logic; all other behaviour identical.

Verification
REQ-029 Reset: rst_n=0 one edge with in_valid=1, A=1, B=2 -> result=0, Zero=1, C_out=0, Negative=0, out_valid=0.
REQ-030 Opcode sweep, WIDTH=8, back-to-back: (ctrl0,A=1,B=2)->3; (ctrl1,A=5,B=3)->2, C_out=1; (ctrl2,A=3,B=2)->2; (ctrl3,A=3,B=2)->3; each one cycle after issue, out_valid=1 each cycle.
REQ-031 Boundaries: ADD 255+1 -> 0, C_out=1, Zero=1; SUB 0-1 -> 255, C_out=0, Negative=1; SUB 7-7 -> 0, C_out=1, Zero=1.
REQ-032 Hold: valid ADD 1+2, then in_valid=0 with A=9, B=9 -> result stays 3, out_valid=0.
REQ-033 With ALU_OVERFLOW_EN: ADD 127+1 -> 128, V=1, Negative=1; SUB 128-1 -> 127, V=1; ADD 1+2 -> V=0.
REQ-034 Mid-stream reset: valid operations streaming, rst_n=0 one edge -> outputs at reset values next cycle, following valid operation resumes with 1-cycle latency.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU client (master) and the ALU (slave).
// V exists only when ALU_OVERFLOW_EN is defined.
interface alu_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       control;
  logic             in_valid;
  logic             C_out;
  logic             Zero;
  logic             Negative;
`ifdef ALU_OVERFLOW_EN
  logic             V;
`endif
  logic [WIDTH-1:0] result;
  logic             out_valid;

`ifdef ALU_OVERFLOW_EN
  modport master (output A, B, control, in_valid,
                  input  C_out, Zero, Negative, V, result, out_valid);
  modport slave  (input  A, B, control, in_valid,
                  output C_out, Zero, Negative, V, result, out_valid);
`else
  modport master (output A, B, control, in_valid,
                  input  C_out, Zero, Negative, result, out_valid);
  modport slave  (input  A, B, control, in_valid,
                  output C_out, Zero, Negative, result, out_valid);
`endif
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU (ADD/SUB/AND/OR) with carry, zero and sign flags.
// Defining ALU_OVERFLOW_EN adds the signed-overflow flag V.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } opcode_e;

  opcode_e          w_op;
  logic [WIDTH-1:0] w_bOperand;
  logic             w_carryIn;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_negative;
  logic             r_outValid;

  // SUB reuses the adder as A + ~B + 1 so the carry out doubles as "no borrow".
  always_comb begin
    w_op       = opcode_e'(bus.control);
    w_bOperand = bus.B;
    w_carryIn  = 1'b0;
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    if (w_op == OP_SUB) begin
      w_bOperand = ~bus.B;
      w_carryIn  = 1'b1;
    end
    w_sum = {1'b0, bus.A} + {1'b0, w_bOperand} + {{WIDTH{1'b0}}, w_carryIn};
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (bus.A[WIDTH-1] == w_bOperand[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  w_result = bus.A & bus.B;
      OP_OR:   w_result = bus.A | bus.B;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b1;
      r_negative <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result   <= w_result;
        r_carry    <= w_carry;
        r_zero     <= (w_result == '0);
        r_negative <= w_result[WIDTH-1];
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (bus.in_valid) begin
      r_overflow <= w_overflow;
    end
  end

  assign bus.V = r_overflow;
`else
  logic w_unusedOverflow;
  assign w_unusedOverflow = w_overflow;
`endif

  assign bus.result    = r_result;
  assign bus.C_out     = r_carry;
  assign bus.Zero      = r_zero;
  assign bus.Negative  = r_negative;
  assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the registered ALU; V checks compile in
// only when ALU_OVERFLOW_EN is defined.
module tb_alu;

  logic clk;
  logic rst_n;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rstN;
    logic       inValid;
    logic [1:0] ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expResult;
    logic       expCarry;
    logic       expZero;
    logic       expNeg;
    logic       expValid;
    logic       expV;
  } vector_t;

  vector_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic compareValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one vector on the falling edge, then let the next rising edge capture it.
  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    rst_n        = v.rstN;
    bus.in_valid = v.inValid;
    bus.control  = v.ctrl;
    bus.A        = v.a;
    bus.B        = v.b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vector_t v);
    compareValue({v.name, ".result"},    bus.result,           v.expResult);
    compareValue({v.name, ".C_out"},     {7'd0, bus.C_out},    {7'd0, v.expCarry});
    compareValue({v.name, ".Zero"},      {7'd0, bus.Zero},     {7'd0, v.expZero});
    compareValue({v.name, ".Negative"},  {7'd0, bus.Negative}, {7'd0, v.expNeg});
    compareValue({v.name, ".out_valid"}, {7'd0, bus.out_valid},{7'd0, v.expValid});
`ifdef ALU_OVERFLOW_EN
    compareValue({v.name, ".V"},         {7'd0, bus.V},        {7'd0, v.expV});
`endif
  endtask

  task automatic runVector(input vector_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.control  = 2'd0;
    bus.A        = 8'd0;
    bus.B        = 8'd0;

    //               name         rstN inV ctrl  a      b      result  C  Z  N  vld V
    vecs.push_back('{"reset",      0,  1,  0,  8'd1,  8'd2,   8'd0,  0, 1, 0, 0, 0});
    vecs.push_back('{"add1p2",     1,  1,  0,  8'd1,  8'd2,   8'd3,  0, 0, 0, 1, 0});
    vecs.push_back('{"sub5m3",     1,  1,  1,  8'd5,  8'd3,   8'd2,  1, 0, 0, 1, 0});
    vecs.push_back('{"and3a2",     1,  1,  2,  8'd3,  8'd2,   8'd2,  0, 0, 0, 1, 0});
    vecs.push_back('{"or3o2",      1,  1,  3,  8'd3,  8'd2,   8'd3,  0, 0, 0, 1, 0});
    vecs.push_back('{"add255p1",   1,  1,  0,  8'd255,8'd1,   8'd0,  1, 1, 0, 1, 0});
    vecs.push_back('{"sub0m1",     1,  1,  1,  8'd0,  8'd1,   8'd255,0, 0, 1, 1, 0});
    vecs.push_back('{"sub7m7",     1,  1,  1,  8'd7,  8'd7,   8'd0,  1, 1, 0, 1, 0});
    vecs.push_back('{"add1p2b",    1,  1,  0,  8'd1,  8'd2,   8'd3,  0, 0, 0, 1, 0});
    vecs.push_back('{"hold",       1,  0,  0,  8'd9,  8'd9,   8'd3,  0, 0, 0, 0, 0});
    vecs.push_back('{"add200p100", 1,  1,  0,  8'd200,8'd100, 8'd44, 1, 0, 0, 1, 0});
    vecs.push_back('{"sub3m5",     1,  1,  1,  8'd3,  8'd5,   8'd254,0, 0, 1, 1, 0});
    vecs.push_back('{"andZero",    1,  1,  2,  8'hF0, 8'h0F,  8'd0,  0, 1, 0, 1, 0});
    vecs.push_back('{"orNeg",      1,  1,  3,  8'h80, 8'h01,  8'h81, 0, 0, 1, 1, 0});
    vecs.push_back('{"add127p1",   1,  1,  0,  8'd127,8'd1,   8'd128,0, 0, 1, 1, 1});
    vecs.push_back('{"holdOvf",    1,  0,  2,  8'd0,  8'd0,   8'd128,0, 0, 1, 0, 1});
    vecs.push_back('{"sub128m1",   1,  1,  1,  8'd128,8'd1,   8'd127,1, 0, 0, 1, 1});
    vecs.push_back('{"add1p2c",    1,  1,  0,  8'd1,  8'd2,   8'd3,  0, 0, 0, 1, 0});

    foreach (vecs[i]) runVector(vecs[i]);

    // Mid-stream reset: the operation presented with rst_n low is dropped, not delayed.
    runVector('{"msAdd",     1, 1, 0, 8'd10, 8'd20, 8'd30, 0, 0, 0, 1, 0});
    runVector('{"msOvf",     1, 1, 0, 8'd100,8'd50, 8'd150,0, 0, 1, 1, 1});
    runVector('{"msReset",   0, 1, 0, 8'd50, 8'd50, 8'd0,  0, 1, 0, 0, 0});
    runVector('{"msResume",  1, 1, 0, 8'd4,  8'd5,  8'd9,  0, 0, 0, 1, 0});
    runVector('{"msIdle",    1, 0, 1, 8'd1,  8'd9,  8'd9,  0, 0, 0, 0, 0});
    runVector('{"msResetIdle",0,0, 0, 8'd0,  8'd0,  8'd0,  0, 1, 0, 0, 0});
    runVector('{"msAfter",   1, 1, 1, 8'd9,  8'd4,  8'd5,  1, 0, 0, 1, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
